// File: rtl/mux32_pkg.sv
// Shared constants and a lane-extraction helper for the 32:1 registered select mux.
package mux32_pkg;

   localparam int N_LANES    = 32;
   localparam int HALF_LANES = 16;
   localparam int SEL_W      = 5;
   localparam int MAX_W      = 64;

   // Returns lane idx (w bits wide, zero-extended) of a packed N_LANES-lane vector.
   function automatic logic [MAX_W-1:0] lane_of(input logic [N_LANES*MAX_W-1:0] vec,
                                                 input int idx, input int w);
      logic [MAX_W-1:0] r;
      r = '0;
      for (int b = 0; b < MAX_W; b++) begin
         if (b < w) r[b] = vec[idx*w + b];
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_16.sv
// Sixteen-lane select built as a four-level tree of mux_2; sel[0] picks at the leaves.
module mux_16
   import mux32_pkg::*;
#(
   parameter int DATA_W = 1
) (
   input  logic [HALF_LANES*DATA_W-1:0] in_data,
   input  logic [3:0]                   sel,
   output logic [DATA_W-1:0]            out_data
);

   logic [8*DATA_W-1:0] lvl1;
   logic [4*DATA_W-1:0] lvl2;
   logic [2*DATA_W-1:0] lvl3;

   for (genvar i = 0; i < 8; i++) begin : g_lvl1
      mux_2 #(.DATA_W(DATA_W)) u_mux (
         .in_data (in_data[i*2*DATA_W +: 2*DATA_W]),
         .sel     (sel[0]),
         .out_data(lvl1[i*DATA_W +: DATA_W])
      );
   end

   for (genvar i = 0; i < 4; i++) begin : g_lvl2
      mux_2 #(.DATA_W(DATA_W)) u_mux (
         .in_data (lvl1[i*2*DATA_W +: 2*DATA_W]),
         .sel     (sel[1]),
         .out_data(lvl2[i*DATA_W +: DATA_W])
      );
   end

   for (genvar i = 0; i < 2; i++) begin : g_lvl3
      mux_2 #(.DATA_W(DATA_W)) u_mux (
         .in_data (lvl2[i*2*DATA_W +: 2*DATA_W]),
         .sel     (sel[2]),
         .out_data(lvl3[i*DATA_W +: DATA_W])
      );
   end

   mux_2 #(.DATA_W(DATA_W)) u_root (
      .in_data (lvl3),
      .sel     (sel[3]),
      .out_data(out_data)
   );

endmodule

// File: rtl/mux_2.sv
// Two-lane select: out_data = sel ? lane 1 : lane 0.
module mux_2 #(
   parameter int DATA_W = 1
) (
   input  logic [2*DATA_W-1:0] in_data,
   input  logic                sel,
   output logic [DATA_W-1:0]   out_data
);

   assign out_data = sel ? in_data[DATA_W +: DATA_W] : in_data[0 +: DATA_W];

endmodule

// File: rtl/mux32_sel_reg.sv
// Registered 32:1 lane select, one-cycle latency with valid flag.
// Define MUX32_COMB_OUT_EN to add the zero-latency comb_data output.
module mux32_sel_reg
   import mux32_pkg::*;
#(
   parameter int DATA_W = 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [N_LANES*DATA_W-1:0] in_data,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      in_valid,
   output logic [DATA_W-1:0]         out_data,
`ifdef MUX32_COMB_OUT_EN
   output logic [DATA_W-1:0]         comb_data,
`endif
   output logic                      out_valid
);

   logic [DATA_W-1:0] lo_p0;
   logic [DATA_W-1:0] hi_p0;
   logic [DATA_W-1:0] result_p0;

   mux_16 #(.DATA_W(DATA_W)) u_lo (
      .in_data (in_data[0 +: HALF_LANES*DATA_W]),
      .sel     (sel[3:0]),
      .out_data(lo_p0)
   );

   mux_16 #(.DATA_W(DATA_W)) u_hi (
      .in_data (in_data[HALF_LANES*DATA_W +: HALF_LANES*DATA_W]),
      .sel     (sel[3:0]),
      .out_data(hi_p0)
   );

   mux_2 #(.DATA_W(DATA_W)) u_half (
      .in_data ({hi_p0, lo_p0}),
      .sel     (sel[4]),
      .out_data(result_p0)
   );

`ifdef MUX32_COMB_OUT_EN
   assign comb_data = result_p0;
`endif

   // p0 -> output register; data holds while in_valid is low
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) out_data <= result_p0;
      end
   end

endmodule

// File: tb/tb_mux32_sel_reg.sv
// Bench for mux32_sel_reg: a 1-bit and an 8-bit instance against a lane-array model.
module tb_mux32_sel_reg;
   import mux32_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;

   logic [31:0]  d1 = '0;
   logic [4:0]   s1 = '0;
   logic         v1 = 1'b0;
   logic         o1, ov1;

   logic [255:0] d8 = '0;
   logic [4:0]   s8 = '0;
   logic         v8 = 1'b0;
   logic [7:0]   o8;
   logic         ov8;
`ifdef MUX32_COMB_OUT_EN
   logic         c1;
   logic [7:0]   c8;
`endif

   int chk = 0;
   int err = 0;
   bit started = 1'b0;

   logic [7:0] lanes8 [32];
   logic       e1, ev1, ev8;
   logic [7:0] e8;

   mux32_sel_reg #(.DATA_W(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .in_data(d1), .sel(s1), .in_valid(v1),
      .out_data(o1),
`ifdef MUX32_COMB_OUT_EN
      .comb_data(c1),
`endif
      .out_valid(ov1)
   );

   mux32_sel_reg #(.DATA_W(8)) u_dut8 (
      .clk(clk), .reset_n(reset_n), .in_data(d8), .sel(s8), .in_valid(v8),
      .out_data(o8),
`ifdef MUX32_COMB_OUT_EN
      .comb_data(c8),
`endif
      .out_valid(ov8)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the selected lane appears one edge after an accepted request.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         e1 <= 1'b0; ev1 <= 1'b0;
         e8 <= '0;   ev8 <= 1'b0;
      end else begin
         ev1 <= v1;
         if (v1) e1 <= 1'(lane_of(2048'(d1), int'(s1), 1));
         ev8 <= v8;
         if (v8) e8 <= lanes8[s8];
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("model_o1", {63'd0, o1}, {63'd0, e1});
         check("model_ov1", {63'd0, ov1}, {63'd0, ev1});
         check("model_o8", {56'd0, o8}, {56'd0, e8});
         check("model_ov8", {63'd0, ov8}, {63'd0, ev8});
      end
   end

`ifdef MUX32_COMB_OUT_EN
   always @(posedge clk) begin
      if (started) begin
         check("comb1", {63'd0, c1}, {63'd0, 1'(lane_of(2048'(d1), int'(s1), 1))});
         check("comb8", {56'd0, c8}, {56'd0, lanes8[s8]});
      end
   end
`endif

   task automatic issue1(input logic [31:0] d, input logic [4:0] s, input logic exp);
      @(negedge clk);
      d1 = d; s1 = s; v1 = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("lit_d%0h_s%0d", d, s), {63'd0, o1}, {63'd0, exp});
      check("lit_valid", {63'd0, ov1}, 64'd1);
   endtask

   initial begin
      int order [32];
      int j, tmp;

      for (int k = 0; k < 32; k++) begin
         lanes8[k] = 8'(k + 16);
         d8[k*8 +: 8] = 8'(k + 16);
      end

      // Reset held with live inputs
      d1 = 32'hFFFF_FFFF; v1 = 1'b1; s1 = 5'd7;
      v8 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_o1", {63'd0, o1}, 64'd0);
      check("rst_ov1", {63'd0, ov1}, 64'd0);
      check("rst_o8", {56'd0, o8}, 64'd0);
      check("rst_ov8", {63'd0, ov8}, 64'd0);
      @(negedge clk);
      v1 = 1'b0; v8 = 1'b0;
      reset_n = 1'b1;
      started = 1'b1;

      issue1(32'h0000_0001, 5'd0, 1'b1);
      issue1(32'h0000_0001, 5'd1, 1'b0);
      issue1(32'h0000_AAAA, 5'd0, 1'b0);
      issue1(32'h0000_AAAA, 5'd1, 1'b1);
      issue1(32'h0000_AAAA, 5'd2, 1'b0);
      issue1(32'h0000_AAAA, 5'd3, 1'b1);
      issue1(32'h0000_F000, 5'd0, 1'b0);
      issue1(32'h0000_F000, 5'd12, 1'b1);
      issue1(32'h0000_F000, 5'd30, 1'b0);
      issue1(32'h8001_0000, 5'd31, 1'b1);
      issue1(32'h8001_0000, 5'd16, 1'b1);
      issue1(32'h8001_0000, 5'd15, 1'b0);
      issue1(32'h0000_0000, 5'd31, 1'b0);
      for (int k = 0; k < 32; k++) issue1(32'hFFFF_FFFF, 5'(k), 1'b1);

      // Valid gating: output holds, valid drops
      issue1(32'h0000_0008, 5'd3, 1'b1);
      @(negedge clk);
      v1 = 1'b0; s1 = 5'd0; d1 = 32'h0;
      @(posedge clk);
      #1;
      check("gate_hold", {63'd0, o1}, 64'd1);
      check("gate_valid", {63'd0, ov1}, 64'd0);

      // Mid-stream asynchronous reset
      issue1(32'hFFFF_FFFF, 5'd9, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_o1", {63'd0, o1}, 64'd0);
      check("arst_ov1", {63'd0, ov1}, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      v1 = 1'b0;
      issue1(32'h0000_0004, 5'd2, 1'b1);
      @(negedge clk);
      v1 = 1'b0;

      // DATA_W=8 sweep in shuffled order
      for (int k = 0; k < 32; k++) order[k] = k;
      for (int k = 31; k > 0; k--) begin
         j = int'($urandom_range(k, 0));
         tmp = order[k]; order[k] = order[j]; order[j] = tmp;
      end
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         s8 = 5'(order[k]); v8 = 1'b1;
         @(posedge clk);
         #1;
         check($sformatf("lit8_s%0d", order[k]), {56'd0, o8}, 64'(order[k] + 16));
         check("lit8_valid", {63'd0, ov8}, 64'd1);
      end
      @(negedge clk);
      v8 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end

endmodule
